// File: rtl/cache_fill_fsm.sv
// Cache-miss block fill controller: stalls the pipeline, streams one block from memory
// into the data array, then writes tag/valid. Optional fill counter under CACHE_FILL_PERF_EN.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_WIDTH      = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               miss_detected,
    input  logic [ADDR_WIDTH-1:0]              miss_address,
    input  logic                               memory_data_valid,
    input  logic [15:0]                        memory_data,
    output logic                               fsm_busy,
    output logic                               memory_read_en,
    output logic [ADDR_WIDTH-1:0]              memory_address,
    output logic                               write_data_array,
    output logic                               write_tag_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] cache_word_offset,
    output logic [15:0]                        cache_data
`ifdef CACHE_FILL_PERF_EN
    ,
    output logic [15:0]                        fill_count
`endif
);

    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W = OFF_W + 1;
    localparam logic [CNT_W-1:0]      WPB_C     = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0]      LAST_C    = CNT_W'(WORDS_PER_BLOCK - 1);
    // Block size in bytes is 2*WORDS_PER_BLOCK; clearing these bits aligns the base.
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~ADDR_WIDTH'(2 * WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]        recv_cnt_q, recv_cnt_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            base_q      <= base_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        issue_cnt_d       = issue_cnt_q;
        recv_cnt_d        = recv_cnt_q;
        base_d            = base_q;
        memory_read_en    = 1'b0;
        memory_address    = '0;
        write_data_array  = 1'b0;
        write_tag_array   = 1'b0;
        cache_word_offset = '0;

        case (state_q)
            S_IDLE: begin
                if (miss_detected) begin
                    base_d      = miss_address & BASE_MASK;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = S_FILL;
                end
            end

            S_FILL: begin
                // Issue and receive sides advance independently and may overlap.
                if (issue_cnt_q < WPB_C) begin
                    memory_read_en = 1'b1;
                    memory_address = base_q + ADDR_WIDTH'({issue_cnt_q, 1'b0});
                    issue_cnt_d    = issue_cnt_q + CNT_W'(1);
                end
                if (memory_data_valid && (recv_cnt_q < WPB_C)) begin
                    write_data_array  = 1'b1;
                    cache_word_offset = recv_cnt_q[OFF_W-1:0];
                    recv_cnt_d        = recv_cnt_q + CNT_W'(1);
                    if (recv_cnt_q == LAST_C) begin
                        write_tag_array = 1'b1;
                        state_d         = S_DONE;
                    end
                end
            end

            S_DONE: begin
                issue_cnt_d = '0;
                recv_cnt_d  = '0;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stall starts combinationally in the miss cycle; held low while in reset.
    assign fsm_busy   = rst_n & ((state_q != S_IDLE) | miss_detected);
    assign cache_data = memory_data;

`ifdef CACHE_FILL_PERF_EN
    logic [15:0] fill_count_q, fill_count_d;

    always_comb begin
        fill_count_d = fill_count_q;
        if (write_tag_array && (fill_count_q != 16'hFFFF)) begin
            fill_count_d = fill_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_count_q <= '0;
        end else begin
            fill_count_q <= fill_count_d;
        end
    end

    assign fill_count = fill_count_q;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized self-checking bench for cache_fill_fsm with a fixed-latency memory model
// and a closed-form per-cycle expectation of each fill.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        memory_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [2:0]  cache_word_offset;
    logic [15:0] cache_data;
`ifdef CACHE_FILL_PERF_EN
    logic [15:0] fill_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_fills = 0;
    logic [15:0] salt;
    int due_q[$];
    logic [15:0] dat_q[$];

    cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_WIDTH(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .memory_read_en    (memory_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .cache_word_offset (cache_word_offset),
        .cache_data        (cache_data)
`ifdef CACHE_FILL_PERF_EN
        ,
        .fill_count        (fill_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input int addr);
        return 16'((addr * 37) ^ 16'h5A3C) ^ salt;
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, " busy"},  32'(fsm_busy), 32'd0);
        check_eq({tag, " rd"},    32'(memory_read_en), 32'd0);
        check_eq({tag, " addr"},  32'(memory_address), 32'd0);
        check_eq({tag, " wdata"}, 32'(write_data_array), 32'd0);
        check_eq({tag, " wtag"},  32'(write_tag_array), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            miss_detected     = 1'b0;
            miss_address      = 16'($urandom);
            memory_data_valid = 1'($urandom_range(0, 1));
            memory_data       = 16'($urandom);
            #1;
            check_quiet("idle");
            check_eq("idle passthru", 32'(cache_data), 32'(memory_data));
        end
    endtask

    // One fill: miss at k=0, reads at k=1..8, data at k=lat+1..lat+8, tag at lat+8, DONE at lat+9.
    task automatic do_fill(input logic [15:0] a, input int lat, input bit hold, input int abort_at);
        int b;
        bit erd, ewd, ewt;
        int eoff;
        b = (int'(a) / 16) * 16;
        due_q.delete();
        dat_q.delete();
        for (int k = 0; k <= lat + 9; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                rst_n             = 1'b0;
                miss_detected     = 1'b1;
                memory_data_valid = 1'b1;
                memory_data       = 16'($urandom);
                #1;
                check_quiet("abort");
                check_eq("abort offset", 32'(cache_word_offset), 32'd0);
                exp_fills = 0;
`ifdef CACHE_FILL_PERF_EN
                check_eq("abort fill_count", 32'(fill_count), 32'd0);
`endif
                @(negedge clk);
                rst_n             = 1'b1;
                miss_detected     = 1'b0;
                memory_data_valid = 1'b0;
                #1;
                check_quiet("post-abort");
                due_q.delete();
                dat_q.delete();
                return;
            end
            miss_detected = (k == 0) || hold;
            miss_address  = (k == 0) ? a : 16'($urandom);
            if (due_q.size() > 0 && due_q[0] == k) begin
                memory_data_valid = 1'b1;
                memory_data       = dat_q[0];
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end else begin
                memory_data_valid = (k == 0 || k == lat + 9) ? 1'b1 : 1'b0;
                memory_data       = 16'($urandom);
            end
            #1;
            erd  = (k >= 1) && (k <= 8);
            ewd  = (k >= lat + 1) && (k <= lat + 8);
            ewt  = (k == lat + 8);
            eoff = k - lat - 1;
            check_eq("busy", 32'(fsm_busy), 32'd1);
            check_eq("rd", 32'(memory_read_en), 32'(erd));
            check_eq("addr", 32'(memory_address), erd ? 32'((b + 2 * (k - 1)) % 65536) : 32'd0);
            check_eq("wdata", 32'(write_data_array), 32'(ewd));
            check_eq("wtag", 32'(write_tag_array), 32'(ewt));
            check_eq("passthru", 32'(cache_data), 32'(memory_data));
            if (ewd) begin
                check_eq("offset", 32'(cache_word_offset), 32'(eoff));
                check_eq("word", 32'(cache_data), 32'(mem_word((b + 2 * eoff) % 65536)));
            end
`ifdef CACHE_FILL_PERF_EN
            check_eq("fill_count", 32'(fill_count), (k == lat + 9) ? 32'(exp_fills + 1) : 32'(exp_fills));
`endif
            if (memory_read_en) begin
                due_q.push_back(k + lat);
                dat_q.push_back(mem_word(int'(memory_address)));
            end
        end
        exp_fills++;
    endtask

    initial begin
        salt              = 16'($urandom);
        rst_n             = 1'b0;
        miss_detected     = 1'b1;
        miss_address      = 16'h1236;
        memory_data_valid = 1'b1;
        memory_data       = 16'hBEEF;
        #3;
        check_quiet("reset");
        check_eq("reset offset", 32'(cache_word_offset), 32'd0);
        check_eq("reset passthru", 32'(cache_data), 32'h0000BEEF);
`ifdef CACHE_FILL_PERF_EN
        check_eq("reset fill_count", 32'(fill_count), 32'd0);
`endif
        @(negedge clk);
        rst_n         = 1'b1;
        miss_detected = 1'b0;
        idle_cycles(2);

        do_fill(16'h1236, 4, 1'b0, -1);
        idle_cycles(1);
        do_fill(16'h1000, 3, 1'b1, -1);
        do_fill(16'h2000, 2, 1'b0, -1);
        idle_cycles(1);
        do_fill(16'hFFFF, 5, 1'b0, -1);
        idle_cycles(2);
        do_fill(16'h0100, 2, 1'b0, 6);
        do_fill(16'h0040, 3, 1'b0, -1);
        idle_cycles(1);

        for (int i = 0; i < 20; i++) begin
            do_fill(16'($urandom), int'($urandom_range(1, 6)), ($urandom_range(0, 3) == 0), -1);
            idle_cycles(int'($urandom_range(0, 2)));
        end
        idle_cycles(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
